sync_fifo16x8: RTL and testbench

Single-clock synchronous FIFO, 16-bit wide, 8 entries deep, with Altera-scfifo-style request/flag semantics. It buffers sample words between a producer FSM and a consumer FSM in the same 50 MHz domain. It provides occupancy count, empty and full flags, and protection against overflow and underflow.

---
 rtl/sync_fifo16x8_pkg.sv | 13 +
 rtl/sync_fifo16x8_if.sv | 24 ++
 rtl/sync_fifo16x8_ram.sv | 44 ++++
 rtl/sync_fifo16x8.sv | 76 +++++++
 tb/tb_sync_fifo16x8.sv | 133 +++++++++++++
 5 files changed

// File: rtl/sync_fifo16x8_pkg.sv
// Shared types and sizing for the 16x8 synchronous FIFO.
// Show-ahead mode is selected with the SYNC_FIFO_SHOWAHEAD_EN macro.
package fifo_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/sync_fifo16x8_if.sv
// Producer/consumer bus of the FIFO.
// The master side drives requests and the slave (FIFO) side returns data and flags.
interface sync_fifo16x8_if;
    import fifo_pkg::*;

    word_t data;
    logic  wrreq;
    logic  rdreq;
    word_t q;
    logic  empty;
    logic  full;
    cnt_t  usedw;

    modport master (
        output data, wrreq, rdreq,
        input  q, empty, full, usedw
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, empty, full, usedw
    );

endinterface

// File: rtl/sync_fifo16x8_ram.sv
// DEPTH x DATA_W storage array with a synchronous write port.
// The read port is registered, or combinational when SYNC_FIFO_SHOWAHEAD_EN is defined.
module fifo_ram
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_we,
    input  addr_t i_waddr,
    input  word_t i_wdata,
    input  logic  i_re,
    input  addr_t i_raddr,
    output word_t o_rdata
);

    word_t r_mem [DEPTH];

    // Storage itself is never cleared; only the pointers define valid words.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef SYNC_FIFO_SHOWAHEAD_EN
    logic w_unused;

    assign w_unused = i_re ^ rst_n;
    assign o_rdata  = r_mem[i_raddr];
`else
    word_t r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo16x8.sv
// Single-clock 16-bit x 8 FIFO with scfifo-style request/flag semantics.
// Define SYNC_FIFO_SHOWAHEAD_EN for first-word-fall-through output.
module sync_fifo16x8
    import fifo_pkg::*;
(
    input  logic              clk_50,
    input  logic              aclr_n,
    sync_fifo16x8_if.slave    bus
);

    addr_t r_wptr;
    addr_t r_rptr;
    cnt_t  r_usedw;
    logic  r_empty;
    logic  r_full;

    logic  w_wr_ok;
    logic  w_rd_ok;
    cnt_t  w_usedw_nxt;
    word_t w_ram_q;

    assign w_wr_ok = bus.wrreq & ~r_full;
    assign w_rd_ok = bus.rdreq & ~r_empty;

    always_comb begin
        w_usedw_nxt = r_usedw;
        if (w_wr_ok && !w_rd_ok) begin
            w_usedw_nxt = r_usedw + cnt_t'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            w_usedw_nxt = r_usedw - cnt_t'(1);
        end
    end

    // Flags are registered from the next count so requests never reach them combinationally.
    always_ff @(posedge clk_50 or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usedw <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + addr_t'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + addr_t'(1);
            end
            r_usedw <= w_usedw_nxt;
            r_empty <= (w_usedw_nxt == cnt_t'(0));
            r_full  <= (w_usedw_nxt == cnt_t'(DEPTH));
        end
    end

    fifo_ram u_ram (
        .clk     (clk_50),
        .rst_n   (aclr_n),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr),
        .i_wdata (bus.data),
        .i_re    (w_rd_ok),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

`ifdef SYNC_FIFO_SHOWAHEAD_EN
    assign bus.q = r_empty ? '0 : w_ram_q;
`else
    assign bus.q = w_ram_q;
`endif

    assign bus.empty = r_empty;
    assign bus.full  = r_full;
    assign bus.usedw = r_usedw;

endmodule

// File: tb/tb_sync_fifo16x8.sv
// Self-checking bench for sync_fifo16x8 in normal (registered-q) mode.
// Table-driven fill/drain plus directed sequences for wrap, boundary and reset cases.
module tb_sync_fifo16x8;
    import fifo_pkg::*;

    typedef struct {
        logic  wrreq;
        logic  rdreq;
        word_t data;
        cnt_t  usedw;
        logic  empty;
        logic  full;
        word_t q;
    } vec_t;

    logic clk_50;
    logic aclr_n;
    int   errors;
    int   checks;

    sync_fifo16x8_if bus ();

    sync_fifo16x8 dut (
        .clk_50 (clk_50),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic checkOne(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, then let one rising edge take effect.
    task automatic applyStimulus(input logic wr, input logic rd, input word_t d);
        @(negedge clk_50);
        bus.wrreq = wr;
        bus.rdreq = rd;
        bus.data  = d;
        @(posedge clk_50);
        #1;
    endtask

    task automatic checkOutput(input string name, input int usedw, input logic empty,
                               input logic full, input logic chk_q, input int q);
        checkOne({name, ".usedw"}, int'(bus.usedw), usedw);
        checkOne({name, ".empty"}, int'(bus.empty), int'(empty));
        checkOne({name, ".full"},  int'(bus.full),  int'(full));
        if (chk_q) checkOne({name, ".q"}, int'(bus.q), q);
    endtask

    task automatic step(input string name, input logic wr, input logic rd, input word_t d,
                        input int usedw, input logic empty, input logic full, input int q);
        applyStimulus(wr, rd, d);
        checkOutput(name, usedw, empty, full, 1'b1, q);
    endtask

    vec_t vecs [18];

    initial begin
        errors    = 0;
        checks    = 0;
        aclr_n    = 1'b0;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.data  = '0;

        // Fill 1..8, overflow write of 9, drain 1..8, underflow read.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 1'b0, word_t'(i + 1), cnt_t'(i + 1), 1'b0, (i == 7), 16'd0};
        vecs[8] = '{1'b1, 1'b0, 16'd9, 4'd8, 1'b0, 1'b1, 16'd0};
        for (int i = 0; i < 8; i++)
            vecs[9 + i] = '{1'b0, 1'b1, 16'd0, cnt_t'(7 - i), (i == 7), 1'b0, word_t'(i + 1)};
        vecs[17] = '{1'b0, 1'b1, 16'd0, 4'd0, 1'b1, 1'b0, 16'd8};

        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        aclr_n = 1'b1;
        repeat (2) @(posedge clk_50);
        #1;
        checkOutput("reset_idle", 0, 1'b1, 1'b0, 1'b1, 0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].wrreq, vecs[i].rdreq, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].usedw), vecs[i].empty,
                        vecs[i].full, 1'b1, int'(vecs[i].q));
        end

        // Preload 4 words, then 10 simultaneous read/write cycles across the wrap.
        for (int i = 0; i < 4; i++)
            step($sformatf("pre%0d", i), 1'b1, 1'b0, word_t'(10 + i), i + 1, 1'b0, 1'b0, 8);
        for (int i = 0; i < 10; i++)
            step($sformatf("rw%0d", i), 1'b1, 1'b1, word_t'(100 + i), 4, 1'b0, 1'b0,
                 (i < 4) ? (10 + i) : (96 + i));
        for (int i = 0; i < 4; i++)
            step($sformatf("drain%0d", i), 1'b0, 1'b1, 16'd0, 3 - i, (i == 3), 1'b0, 106 + i);

        // Full with simultaneous requests: only the read proceeds, 55 is dropped.
        for (int i = 0; i < 8; i++)
            step($sformatf("fill%0d", i), 1'b1, 1'b0, word_t'(200 + i), i + 1, 1'b0, (i == 7), 109);
        step("full_rw", 1'b1, 1'b1, 16'd55, 7, 1'b0, 1'b0, 200);
        for (int i = 0; i < 7; i++)
            step($sformatf("full_drain%0d", i), 1'b0, 1'b1, 16'd0, 6 - i, (i == 6), 1'b0, 201 + i);

        // Empty with simultaneous requests: only the write proceeds, q holds.
        step("empty_rw", 1'b1, 1'b1, 16'd77, 1, 1'b0, 1'b0, 207);
        step("empty_rw_read", 1'b0, 1'b1, 16'd0, 0, 1'b1, 1'b0, 77);

        // Reset pulse mid-stream clears everything immediately.
        for (int i = 0; i < 5; i++)
            step($sformatf("load%0d", i), 1'b1, 1'b0, word_t'(i + 1), i + 1, 1'b0, 1'b0, 77);
        @(negedge clk_50);
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        #4;
        aclr_n = 1'b0;
        #1;
        checkOutput("reset_mid", 0, 1'b1, 1'b0, 1'b1, 0);
        aclr_n = 1'b1;
        step("post_rst_wr", 1'b1, 1'b0, 16'd42, 1, 1'b0, 1'b0, 0);
        step("post_rst_rd", 1'b0, 1'b1, 16'd0, 0, 1'b1, 1'b0, 42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
